keypad_scan: RTL and testbench

- Scans the 4x3 matrix keypad and debounces it for the tic-tac-toe game.
- Emits one single-cycle `key_valid` pulse carrying a 4-bit key code per clean press.
- Sits directly upstream of the game-state block and replaces its raw edge-triggered `key_data` input with a synchronous, debounced event.
- Gated by `en`, so presses are only reported while the game screen is active.

---
 rtl/keypad_pkg.sv | 48 ++++
 rtl/keypad_scan_if.sv | 34 +++
 rtl/scan_tick_gen.sv | 30 +++
 rtl/keypad_scan.sv | 153 +++++++++++++++
 tb/tb_keypad_scan.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key-code constants, reporter state type and the keypad
// geometry helpers shared by the keypad scanner and the game-state block.
//   KEY_STAR/KEY_HASH : codes of the '*' and '#' keys
//   KEY_MULTI         : full scan saw two or more keys
//   KEY_NONE          : full scan saw no key (also the idle key_data value)
package keypad_pkg;

  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_HASH  = 4'd11;
  localparam logic [3:0] KEY_MULTI = 4'd14;
  localparam logic [3:0] KEY_NONE  = 4'd15;

  typedef enum logic {
    ST_IDLE,
    ST_PRESSED
  } rep_state_e;

  // Rows 0..2 hold the digits 1..9 in reading order; row 3 is *, 0, #.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  // One-hot active-low column drive.
  function automatic logic [2:0] col_drive(input logic [1:0] col);
    logic [2:0] drv;
    case (col)
      2'd0:    drv = 3'b110;
      2'd1:    drv = 3'b101;
      default: drv = 3'b011;
    endcase
    return drv;
  endfunction

  function automatic logic is_key(input logic [3:0] code);
    return code <= KEY_HASH;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad-side and game-side signals of the keypad scanner.
//   en        : report enable (from game screen logic)
//   key_row   : raw active-low keypad rows, asynchronous to clk
//   key_col   : active-low one-hot column drive
//   key_data  : code of the last accepted key
//   key_valid : one-clk pulse per accepted key
//   key_held  : accepted key still debounced-pressed
// master = the side that drives en/key_row, slave = the scanner.
interface keypad_scan_if;
  logic       en;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [3:0] key_data;
  logic       key_valid;
  logic       key_held;

  modport master (
    output en,
    output key_row,
    input  key_col,
    input  key_data,
    input  key_valid,
    input  key_held
  );

  modport slave (
    input  en,
    input  key_row,
    output key_col,
    output key_data,
    output key_valid,
    output key_held
  );
endinterface

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running divider producing a single-clk tick once
// every SCAN_DIV clocks (tick while the count sits at SCAN_DIV-1).
//   clk, rst : system clock, synchronous active-high reset
//   tick_o   : scan tick
module scan_tick_gen #(
  parameter int SCAN_DIV = 25000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 matrix keypad scanner, debouncer and press reporter.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : keypad_scan_if.slave (en, key_row in; key_col, key_data,
//              key_valid, key_held out)
// Rows are synchronised, sampled once per column tick, merged into one
// code per full scan, debounced over DEBOUNCE_SCANS identical scans and
// reported once per press; a full release re-arms the reporter.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic           clk,
  input logic           rst,
  keypad_scan_if.slave  bus
);

  localparam int SC_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(DEBOUNCE_SCANS);

  logic             tick;
  logic [3:0]       row_meta_q, row_sync_q;
  logic [1:0]       col_q, col_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [3:0]       acc_code_q, acc_code_d;
  logic [3:0]       prev_code_q, prev_code_d;
  logic [SC_W-1:0]  stable_q, stable_d;
  logic             scan_done_q, scan_end;
  logic [2:0]       col_hits, hits_total;
  logic [3:0]       col_code, scan_code;
  rep_state_e       state_q;
  logic             armed_q;
  logic [3:0]       key_data_q;
  logic             key_valid_q, key_held_q;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign bus.key_col   = col_drive(col_q);
  assign bus.key_data  = key_data_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;

  // Stage: row synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= bus.key_row;
      row_sync_q <= row_meta_q;
    end
  end

  // Stage: column sample and full-scan merge
  always_comb begin
    col_hits = 3'd0;
    col_code = KEY_NONE;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_map(2'(r), col_q);
      end
    end
    // acc_cnt_q saturates at 2, so the sum never exceeds 6.
    hits_total = {1'b0, acc_cnt_q} + col_hits;
    if (hits_total == 3'd0)      scan_code = KEY_NONE;
    else if (hits_total == 3'd1) scan_code = (acc_cnt_q == 2'd1) ? acc_code_q : col_code;
    else                         scan_code = KEY_MULTI;
  end

  always_comb begin
    col_d       = col_q;
    acc_cnt_d   = acc_cnt_q;
    acc_code_d  = acc_code_q;
    prev_code_d = prev_code_q;
    stable_d    = stable_q;
    scan_end    = tick && (col_q == 2'd2);
    if (tick) begin
      if (col_q == 2'd2) begin
        col_d      = 2'd0;
        acc_cnt_d  = 2'd0;
        acc_code_d = KEY_NONE;
      end else begin
        col_d     = col_q + 2'd1;
        acc_cnt_d = (hits_total >= 3'd2) ? 2'd2 : hits_total[1:0];
        if (acc_cnt_q == 2'd0) acc_code_d = col_code;
      end
    end
    // Stage: debounce, once per full scan
    if (scan_end) begin
      if (scan_code == prev_code_q) begin
        if (stable_q != SC_MAX) stable_d = stable_q + SC_W'(1);
      end else begin
        stable_d    = SC_W'(1);
        prev_code_d = scan_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= 2'd0;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= KEY_NONE;
      prev_code_q <= KEY_NONE;
      stable_q    <= '0;
      scan_done_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      prev_code_q <= prev_code_d;
      stable_q    <= stable_d;
      scan_done_q <= scan_end;
    end
  end

  // Stage: reporter, acts the clock after a full scan completes.
  // MULTI matches neither branch, so it leaves state and armed untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b1;
      key_data_q  <= KEY_NONE;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done_q && (stable_q == SC_MAX)) begin
        if (prev_code_q == KEY_NONE) begin
          state_q    <= ST_IDLE;
          key_held_q <= 1'b0;
          armed_q    <= 1'b1;
        end else if (is_key(prev_code_q) && (state_q == ST_IDLE) && armed_q && bus.en) begin
          state_q     <= ST_PRESSED;
          key_data_q  <= prev_code_q;
          key_valid_q <= 1'b1;
          key_held_q  <= 1'b1;
          armed_q     <= 1'b0;
        end
      end
      // A key already down when the game screen becomes active must be
      // released before it counts; disabling therefore disarms.
      if (!bus.en) armed_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int SCAN_CLKS = 3 * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_if kp();

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (kp)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] cur_mask = '0;
  logic        cur_en = 1'b1;
  bit          at_boundary = 0;

  logic [3:0] obs_q[$];
  int         obs_cyc[$];
  logic [3:0] exp_q[$];

  // scan-level reference model state
  logic [3:0] m_prev;
  int         m_streak;
  bit         m_armed, m_held, m_pending;

  function automatic int key_row_of(input int k);
    if (k >= 1 && k <= 9) return (k - 1) / 3;
    return 3;
  endfunction

  function automatic int key_colidx_of(input int k);
    if (k >= 1 && k <= 9) return (k - 1) % 3;
    if (k == 0) return 1;
    if (k == 10) return 0;
    return 2;
  endfunction

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    kp.key_row = 4'hF;
    for (int k = 0; k < 12; k++)
      if (cur_mask[k] && (kp.key_col[key_colidx_of(k)] == 1'b0))
        kp.key_row[key_row_of(k)] = 1'b0;
  end

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      obs_q.push_back(kp.key_data);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic logic [3:0] mask_code(input logic [11:0] m);
    int n;
    logic [3:0] c;
    n = 0;
    c = 4'hF;
    for (int k = 0; k < 12; k++) if (m[k]) begin n++; c = 4'(k); end
    if (n == 0) return 4'hF;
    if (n > 1) return 4'hE;
    return c;
  endfunction

  task automatic model_reset();
    m_prev = 4'hF; m_streak = 0; m_armed = 1; m_held = 0; m_pending = 0;
  endtask

  task automatic model_end_scan(input logic [3:0] code);
    if (code == m_prev) begin
      if (m_streak < DB) m_streak++;
    end else begin
      m_streak = 1;
      m_prev = code;
    end
    m_pending = 1;
  endtask

  task automatic model_eval(input logic en_now);
    if (!en_now) m_armed = 0;
    if (m_pending && m_streak == DB) begin
      if (m_prev <= 4'd11 && m_armed && en_now) begin
        exp_q.push_back(m_prev);
        m_armed = 0;
        m_held = 1;
      end else if (m_prev == 4'hF) begin
        m_armed = en_now;
        m_held = 0;
      end
    end
    m_pending = 0;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic align();
    logic [2:0] prev;
    bit found;
    if (!at_boundary) begin
      found = 0;
      for (int i = 0; i < SCAN_CLKS + 1 && !found; i++) begin
        prev = kp.key_col;
        @(negedge clk);
        if (prev == 3'b011 && kp.key_col == 3'b110) found = 1;
      end
      checks++;
      if (!found) begin
        failures++;
        $display("FAIL scan_align got=no_col_wrap required=col_wrap");
      end
      model_end_scan(mask_code(cur_mask));
      at_boundary = 1;
    end
  endtask

  task automatic run_scans(input logic [11:0] mask, input logic en_v, input int n);
    align();
    for (int i = 0; i < n; i++) begin
      cur_mask = mask;
      cur_en = en_v;
      kp.en = en_v;
      model_eval(en_v);
      repeat (SCAN_CLKS) @(negedge clk);
      model_end_scan(mask_code(mask));
    end
    at_boundary = 1;
  endtask

  task automatic settle();
    model_eval(cur_en);
    repeat (2) @(negedge clk);
    at_boundary = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_obs();
    at_boundary = 1;
  endtask

  task automatic test_reset();
    checks++; if (kp.key_col !== 3'b110) begin failures++; $display("FAIL reset_key_col got=%b exp=110", kp.key_col); end
    checks++; if (kp.key_data !== 4'hF) begin failures++; $display("FAIL reset_key_data got=%h exp=f", kp.key_data); end
    checks++; if (kp.key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid got=%b exp=0", kp.key_valid); end
    checks++; if (kp.key_held !== 1'b0) begin failures++; $display("FAIL reset_key_held got=%b exp=0", kp.key_held); end
  endtask

  task automatic test_idle();
    logic [2:0] exp_col;
    clear_obs();
    for (int s = 0; s < 9; s++) begin
      model_eval(1'b1);
      for (int j = 0; j < SCAN_CLKS; j++) begin
        exp_col = 3'b111 & ~(3'b001 << (j / SD));
        checks++;
        if (kp.key_col !== exp_col) begin
          failures++;
          $display("FAIL idle_key_col scan=%0d clk=%0d got=%b exp=%b", s, j, kp.key_col, exp_col);
        end
        @(negedge clk);
      end
      model_end_scan(4'hF);
    end
    at_boundary = 1;
    settle();
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL idle_pulses got=%0d exp=0", obs_q.size()); end
    checks++; if (kp.key_data !== 4'hF) begin failures++; $display("FAIL idle_key_data got=%h exp=f", kp.key_data); end
  endtask

  task automatic test_key5();
    int t0;
    run_scans(12'h000, 1'b1, 1);
    clear_obs();
    t0 = cyc;
    run_scans(12'h020, 1'b1, 6);
    settle();
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL key5_pulses got=%0d exp=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== 4'd5) begin failures++; $display("FAIL key5_code got=%0d exp=5", obs_q[0]); end
      checks++;
      if (obs_cyc[0] - t0 < 24 || obs_cyc[0] - t0 > 56) begin
        failures++; $display("FAIL key5_latency got=%0d exp=24..56", obs_cyc[0] - t0);
      end
    end
    checks++; if (kp.key_held !== 1'b1) begin failures++; $display("FAIL key5_held got=%b exp=1", kp.key_held); end
    clear_obs();
    run_scans(12'h020, 1'b1, 17);
    settle();
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL key5_repeat got=%0d exp=0", obs_q.size()); end
    checks++; if (kp.key_held !== 1'b1) begin failures++; $display("FAIL key5_held_long got=%b exp=1", kp.key_held); end
    run_scans(12'h000, 1'b1, 4);
    settle();
    checks++; if (kp.key_held !== 1'b0) begin failures++; $display("FAIL key5_release_held got=%b exp=0", kp.key_held); end
    checks++; if (kp.key_data !== 4'd5) begin failures++; $display("FAIL key5_data_kept got=%0d exp=5", kp.key_data); end
  endtask

  task automatic test_bounce();
    int pat[8] = '{1, 0, 1, 1, 0, 1, 1, 0};
    clear_obs();
    for (int i = 0; i < 8; i++) run_scans(pat[i] != 0 ? 12'h200 : 12'h000, 1'b1, 1);
    settle();
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", obs_q.size()); end
    clear_obs();
    run_scans(12'h200, 1'b1, 4);
    settle();
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL bounce_stable_pulses got=%0d exp=1", obs_q.size()); end
    checks++; if (kp.key_data !== 4'd9) begin failures++; $display("FAIL bounce_code got=%0d exp=9", kp.key_data); end
    run_scans(12'h000, 1'b1, 4);
  endtask

  task automatic test_multi();
    clear_obs();
    run_scans(12'h002, 1'b1, 4);
    settle();
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL multi_first_pulses got=%0d exp=1", obs_q.size()); end
    checks++; if (kp.key_data !== 4'd1) begin failures++; $display("FAIL multi_first_code got=%0d exp=1", kp.key_data); end
    clear_obs();
    run_scans(12'h00A, 1'b1, 4);
    settle();
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL multi_both_pulses got=%0d exp=0", obs_q.size()); end
    run_scans(12'h002, 1'b1, 4);
    settle();
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL multi_release3_pulses got=%0d exp=0", obs_q.size()); end
    run_scans(12'h000, 1'b1, 4);
    settle();
    checks++; if (kp.key_held !== 1'b0) begin failures++; $display("FAIL multi_release_held got=%b exp=0", kp.key_held); end
    run_scans(12'h002, 1'b1, 4);
    settle();
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL multi_repress_pulses got=%0d exp=1", obs_q.size()); end
    run_scans(12'h000, 1'b1, 4);
  endtask

  task automatic test_enable();
    clear_obs();
    run_scans(12'h800, 1'b0, 4);
    settle();
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL en_low_pulses got=%0d exp=0", obs_q.size()); end
    run_scans(12'h800, 1'b1, 4);
    settle();
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL en_rise_held_pulses got=%0d exp=0", obs_q.size()); end
    run_scans(12'h000, 1'b1, 4);
    run_scans(12'h800, 1'b1, 4);
    settle();
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL en_repress_pulses got=%0d exp=1", obs_q.size()); end
    checks++; if (kp.key_data !== 4'd11) begin failures++; $display("FAIL en_repress_code got=%0d exp=11", kp.key_data); end
    run_scans(12'h000, 1'b1, 4);
  endtask

  task automatic test_reset_mid();
    clear_obs();
    run_scans(12'h001, 1'b1, 5);
    settle();
    checks++; if (kp.key_data !== 4'd0) begin failures++; $display("FAIL rmid_before_code got=%0d exp=0", kp.key_data); end
    pulse_reset();
    checks++; if (kp.key_col !== 3'b110) begin failures++; $display("FAIL rmid_key_col got=%b exp=110", kp.key_col); end
    checks++; if (kp.key_data !== 4'hF) begin failures++; $display("FAIL rmid_key_data got=%h exp=f", kp.key_data); end
    checks++; if (kp.key_held !== 1'b0) begin failures++; $display("FAIL rmid_key_held got=%b exp=0", kp.key_held); end
    run_scans(12'h001, 1'b1, 3);
    settle();
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL rmid_again_pulses got=%0d exp=1", obs_q.size()); end
    checks++; if (kp.key_data !== 4'd0) begin failures++; $display("FAIL rmid_again_code got=%0d exp=0", kp.key_data); end
    run_scans(12'h000, 1'b1, 4);
  endtask

  task automatic test_random();
    int sel;
    logic [11:0] m;
    settle();
    clear_obs();
    for (int s = 0; s < 16; s++) begin
      sel = $urandom_range(0, 9);
      m = '0;
      if (sel >= 4) m[$urandom_range(0, 11)] = 1'b1;
      if (sel >= 8) m[$urandom_range(0, 11)] = 1'b1;
      run_scans(m, 1'b1, $urandom_range(1, 5));
    end
    run_scans(12'h000, 1'b1, 4);
    settle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_pulse_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rand_code idx=%0d got=%0d exp=%0d", i, obs_q[i], exp_q[i]);
      end
    end
    checks++; if (kp.key_held !== m_held) begin failures++; $display("FAIL rand_held got=%b exp=%b", kp.key_held, m_held); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    kp.en = 1'b1;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    at_boundary = 1;
    test_reset();
    test_idle();
    test_key5();
    test_bounce();
    test_multi();
    test_enable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
